alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the single-cycle ALU. It runs the eight base operations in one cycle and adds logical/arithmetic right shift, iterative unsigned multiply and unsigned divide/remainder. A start/busy/done handshake lets the multi-cycle CPU datapath stall on long operations. Result and flags are registered and held until the next completion.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  request; accepted only in a cycle where busy=0
- ALUOp  in  4  operation select, sampled at accept
- regA  in  WIDTH  operand A / shift amount, sampled at accept
- regB  in  WIDTH  operand B, sampled at accept
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: result/zero/divzero updated this cycle
- result  out  WIDTH  registered result, held between done pulses
- zero  out  1  registered, 1 when result==0
- divzero  out  1  registered, 1 when last completed op was divu/remu with B==0

## Operation
- ALUOp encoding; quick ops complete in 1 cycle:
  - 0 add A+B; 1 sub A−B; 2 sll B<<A[SHW-1:0]; 3 or; 4 and
  - 5 sltu (A<B unsigned ? 1:0); 6 slt (signed compare ? 1:0); 7 xor
  - 8 srl B>>A[SHW-1:0]; 9 sra B>>>A[SHW-1:0] (sign-filled)
  - 14, 15 reserved: result 0, zero 1
- Iterative ops, WIDTH steps each:
  - 10 mul: low WIDTH bits of A×B
  - 11 mulhu: high WIDTH bits of unsigned A×B
  - 12 divu: A/B
  - 13 remu: A%B
- Add/sub/mul wrap modulo 2^WIDTH; no overflow flag. Shift amount uses only the low SHW bits of A.
- Multiply: shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per step.
- Divide: restoring, one quotient bit per step.
- B==0 on divu/remu: divu returns all-ones, remu returns A, divzero=1. Latency is unchanged.
- divzero is cleared on every other completion.
- Operands and op are latched at accept. Input changes while busy have no effect.
- FSM:
  - IDLE: start & quick op → compute, done=1 next cycle, stay IDLE. start & iterative op → latch, counter=WIDTH, go RUN.
  - RUN: one step per cycle, counter decrements. When counter reaches 1, write result; done=1 next cycle; go IDLE.
- start while busy=1 is ignored; it is not queued.
- Reset values: result=0, zero=1, done=0, busy=0, divzero=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts it: no done pulse, outputs return to reset values.

## Timing
- Accept edge = rising CLK at which start=1 and busy=0.
- Quick ops: result/zero/divzero/done valid in the cycle after the accept edge, a latency of 1.
- Iterative ops:
  - busy=1 for exactly WIDTH cycles, starting the cycle after accept.
  - done=1 in the following cycle, with busy=0; latency WIDTH+1.
- In the done cycle busy=0, so a start there is accepted. Back-to-back ops run with no bubble.
- done is high for exactly one cycle per accepted op.
- result holds its value until the next done.
- zero and divzero change only with done or Reset.
- Reset has priority over start in the same cycle.

## Test plan
- Reset, then sub A=5, B=5 → next cycle: done=1, result=0, zero=1, busy stays 0. Then add 0xFFFFFFFF+1 → result 0, zero 1 (wrap).
- slt A=0xFFFFFFFF, B=1 → 1. sltu with the same operands → 0. sra B=0x80000000, A=36 → 0xF8000000 (shift uses low 5 bits = 4). srl on the same values → 0x08000000.
- mul A=0x00010000, B=0x00010000 → result 0, zero 1; mulhu → 1.
  - busy high for exactly 32 cycles; done in cycle 33 after accept.
  - A start pulsed mid-op is ignored: no extra done pulse.
- divu 100/7 → 14; remu → 2.
  - divu 5/0 → 0xFFFFFFFF, divzero=1; the following add clears divzero.
- Issue start for mul in the done cycle of a divu → accepted; its done follows 33 cycles later.
- Reset asserted in cycle 10 of a mul:
  - Next cycle: busy=0, result=0, zero=1, and no done pulse ever appears.
  - A following add 1+2 → result 3 one cycle after accept.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops plus shifts, and iterative multiply/divide
// behind a start/busy/done handshake. Result and flags are registered and held until next done.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             divzero
);

    localparam int unsigned CW = SHW + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   quick_res;
    logic               in_iter;
    logic               in_mul;
    logic               op_mul;
    logic               op_div;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   iter_res;

    assign shamt   = regA[SHW-1:0];
    assign in_iter = (ALUOp >= 4'd10) && (ALUOp <= 4'd13);
    assign in_mul  = (ALUOp == 4'd10) || (ALUOp == 4'd11);
    assign op_mul  = (op_q == 4'd10) || (op_q == 4'd11);
    assign op_div  = (op_q == 4'd12) || (op_q == 4'd13);

    always_comb begin
        quick_res = '0;
        case (ALUOp)
            4'd0:    quick_res = regA + regB;
            4'd1:    quick_res = regA - regB;
            4'd2:    quick_res = regB << shamt;
            4'd3:    quick_res = regA | regB;
            4'd4:    quick_res = regA & regB;
            4'd5:    quick_res = {{(WIDTH-1){1'b0}}, (regA < regB)};
            4'd6:    quick_res = {{(WIDTH-1){1'b0}}, ($signed(regA) < $signed(regB))};
            4'd7:    quick_res = regA ^ regB;
            4'd8:    quick_res = regB >> shamt;
            4'd9:    quick_res = $unsigned($signed(regB) >>> shamt);
            default: quick_res = '0;
        endcase
    end

    // acc_q holds {partial product, multiplier} for mul and {remainder, dividend/quotient}
    // for div; opnd_q is the multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_mul) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if ((op_q == 4'd11) || (op_q == 4'd13)) begin
            iter_res = acc_step[2*WIDTH-1:WIDTH];
        end else begin
            iter_res = acc_step[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= StIdle;
            cnt     <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (in_iter) begin
                            op_q   <= ALUOp;
                            opnd_q <= in_mul ? regA : regB;
                            acc_q  <= {{WIDTH{1'b0}}, (in_mul ? regB : regA)};
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= StRun;
                        end else begin
                            result  <= quick_res;
                            zero    <= (quick_res == '0);
                            divzero <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // B==0 falls out of restoring division as all-ones / A naturally
                        result  <= iter_res;
                        zero    <= (iter_res == '0);
                        divzero <= op_div && (opnd_q == '0);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: quick ops, iterative mul/div, handshake and reset.
module tb_alu_mc;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ALUOp = 4'd0;
    logic [W-1:0] regA = '0;
    logic [W-1:0] regB = '0;
    logic         busy, done, zero, divzero;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .ALUOp(ALUOp), .regA(regA), .regB(regB),
        .busy(busy), .done(done), .result(result), .zero(zero), .divzero(divzero)
    );

    always #5 CLK = ~CLK;

    // Drive one request, return #1 after the accept edge with inputs scrambled.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        start = 1'b1; ALUOp = op; regA = a; regB = b;
        @(posedge CLK); #1;
        start = 1'b0; ALUOp = 4'($urandom); regA = $urandom; regB = $urandom;
    endtask

    // Sample each cycle until done; optionally pulse a stray start at cycle poke_at.
    task automatic wait_done(input int poke_at, output int lat, output int bcyc);
        lat = 1; bcyc = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            if (lat == poke_at) begin start = 1'b1; ALUOp = 4'd0; end
            @(posedge CLK); #1;
            start = 1'b0; lat++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1; Reset = 1'b0;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || divzero !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b done=%b dz=%b exp 0", busy, done, divzero);
        end
    endtask

    task automatic test_quick;
        logic [3:0]   ops [12] = '{4'd1, 4'd0, 4'd6, 4'd5, 4'd9, 4'd8, 4'd2, 4'd3, 4'd4, 4'd7,
                                   4'd14, 4'd15};
        logic [W-1:0] as  [12] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd36,
                                   32'd36, 32'd33, 32'hF0, 32'hF0, 32'hFF, 32'd7, 32'd7};
        logic [W-1:0] bs  [12] = '{32'd5, 32'd1, 32'd1, 32'd1, 32'h80000000, 32'h80000000,
                                   32'd1, 32'h0F, 32'h3C, 32'h0F, 32'd9, 32'd9};
        logic [W-1:0] exp [12] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'h08000000,
                                   32'd2, 32'hFF, 32'h30, 32'hF0, 32'd0, 32'd0};
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i]);
            checks++; if (done !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL quick%0d_hs got done=%b busy=%b exp 1/0", i, done, busy);
            end
            checks++; if (result !== exp[i]) begin
                errors++; $display("FAIL quick%0d_result got %h exp %h", i, result, exp[i]);
            end
            checks++; if (zero !== (exp[i] == 0) || divzero !== 1'b0) begin
                errors++; $display("FAIL quick%0d_flags got z=%b dz=%b exp %b/0", i, zero, divzero,
                                   exp[i] == 0);
            end
            @(posedge CLK); #1;
            checks++; if (done !== 1'b0 || result !== exp[i]) begin
                errors++; $display("FAIL quick%0d_hold got done=%b res=%h exp 0/%h", i, done, result,
                                   exp[i]);
            end
        end
    endtask

    task automatic test_mul;
        int lat, bc;
        int extra;
        issue(4'd10, 32'h00010000, 32'h00010000);
        wait_done(6, lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
        checks++; if (bc != 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", bc); end
        checks++; if (result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mul_result got %h z=%b busy=%b exp 0 1 0", result, zero, busy);
        end
        extra = 0;
        repeat (40) begin @(posedge CLK); #1; if (done) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL mul_stray_done got %0d exp 0", extra); end
        issue(4'd11, 32'h00010000, 32'h00010000);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'h1 || zero !== 1'b0) begin
            errors++; $display("FAIL mulhu_result got %h z=%b exp 1 0", result, zero);
        end
        issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'h1) begin errors++; $display("FAIL mul_max got %h exp 1", result); end
        issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL mulhu_max got %h exp fffffffe", result);
        end
    endtask

    task automatic test_div;
        int lat, bc;
        issue(4'd12, 32'd100, 32'd7);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'd14 || divzero !== 1'b0) begin
            errors++; $display("FAIL divu got %h dz=%b exp e 0", result, divzero);
        end
        issue(4'd13, 32'd100, 32'd7);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL remu got %h exp 2", result); end
        issue(4'd12, 32'h80000000, 32'd3);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'h2AAAAAAA) begin
            errors++; $display("FAIL divu_big got %h exp 2aaaaaaa", result);
        end
        issue(4'd12, 32'd5, 32'd0);
        wait_done(0, lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL divz_latency got %0d exp 33", lat); end
        checks++; if (result !== 32'hFFFFFFFF || divzero !== 1'b1) begin
            errors++; $display("FAIL divu_zero got %h dz=%b exp ffffffff 1", result, divzero);
        end
        issue(4'd13, 32'd5, 32'd0);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'd5 || divzero !== 1'b1) begin
            errors++; $display("FAIL remu_zero got %h dz=%b exp 5 1", result, divzero);
        end
        issue(4'd0, 32'd1, 32'd1);
        checks++; if (result !== 32'd2 || divzero !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL divz_clear got %h dz=%b done=%b exp 2 0 1", result, divzero, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(4'd12, 32'd100, 32'd7);
        wait_done(0, lat, bc);
        checks++; if (result !== 32'd14 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_div got %h done=%b exp e 1", result, done);
        end
        issue(4'd10, 32'd3, 32'd5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
        wait_done(0, lat, bc);
        checks++; if (lat != 33 || result !== 32'd15) begin
            errors++; $display("FAIL b2b_mul got lat=%0d res=%h exp 33 f", lat, result);
        end
    endtask

    task automatic test_reset_abort;
        int lat, bc;
        int extra;
        issue(4'd10, 32'd7, 32'd9);
        repeat (9) begin @(posedge CLK); #1; end
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            errors++; $display("FAIL abort_state got busy=%b done=%b res=%h z=%b exp 0 0 0 1",
                               busy, done, result, zero);
        end
        extra = 0;
        repeat (40) begin @(posedge CLK); #1; if (done || busy) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", extra); end
        issue(4'd0, 32'd1, 32'd2);
        checks++; if (result !== 32'd3 || done !== 1'b1) begin
            errors++; $display("FAIL abort_add got %h done=%b exp 3 1", result, done);
        end
    endtask

    initial begin
        test_reset();
        test_quick();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
